// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped cache controller: FSM state encoding and core op codes.
package cache_pkg;
  localparam int STATE_W = 4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WTHRU = 2'b01;
  localparam logic [1:0] OP_WBACK = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    IDLE, LOOKUP, WBACK, WB_COMMIT, REFILL, RF_COMMIT, DONE, FLUSH, FDONE
  } state_t;
endpackage

// File: rtl/cache_flush_cnt.sv
// Line index walker for flush-all; last flags the final entry.
module cache_flush_cnt #(
  parameter int ENTRY_NUM    = 16,
  parameter int ENTRYSEL_WID = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [ENTRYSEL_WID-1:0] cnt,
  output logic                    last
);
  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (inc)    cnt <= cnt + ENTRYSEL_WID'(1);
  end

  assign last = (cnt == ENTRYSEL_WID'(ENTRY_NUM - 1));
endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped cache sequencer: lookup, dirty writeback, refill and flush-all walk.
// Define CACHE_CTRL_WBACK_EN to build in the dirty path (WBACK/WB_COMMIT, ts_wback).
module cache_ctrl_dm
  import cache_pkg::*;
#(
  parameter int ENTRY_NUM    = 16,
  parameter int ENTRYSEL_WID = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
  parameter int TAG_WID      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req,
  input  logic [1:0]              core_op,
  input  logic [TAG_WID-1:0]      core_tag,
  input  logic [ENTRYSEL_WID-1:0] core_ent,
  output logic                    core_ready,
  output logic                    core_busy,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    ts_read,
  output logic                    ts_wthru,
  output logic                    ts_wback,
  output logic [TAG_WID-1:0]      ts_tag,
  output logic [TAG_WID-1:0]      ts_refill_tag,
  output logic [ENTRYSEL_WID-1:0] ts_ent,
  output logic                    ts_valid_clear,
  output logic                    ts_line_refill,
  output logic                    ts_writeback_ok,
  input  logic                    ts_line_miss,
  input  logic                    ts_replace_dirty,
  output logic                    biu_wb_req,
  input  logic                    biu_wb_done,
  output logic                    biu_refill_req,
  input  logic                    biu_refill_done,
  output logic [ENTRYSEL_WID-1:0] biu_ent,
  output logic [TAG_WID-1:0]      biu_tag
);
  state_t                  state, state_nxt;
  logic [1:0]              op_q;
  logic [TAG_WID-1:0]      tag_q;
  logic [ENTRYSEL_WID-1:0] ent_q;
  logic                    flush_q;
  logic [ENTRYSEL_WID-1:0] cnt;
  logic                    cnt_last, cnt_inc, cnt_clr;
  logic                    is_wthru, is_wback;

`ifdef CACHE_CTRL_WBACK_EN
  assign is_wthru = (op_q == OP_WTHRU);
  assign is_wback = (op_q == OP_WBACK);
`else
  // Without the dirty path a write-back request degrades to write-through.
  logic unused_wb;
  assign unused_wb = ts_replace_dirty ^ biu_wb_done;
  assign is_wthru  = (op_q == OP_WTHRU) || (op_q == OP_WBACK);
  assign is_wback  = 1'b0;
`endif

  cache_flush_cnt #(.ENTRY_NUM(ENTRY_NUM), .ENTRYSEL_WID(ENTRYSEL_WID)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt),
    .last(cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      ent_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (flush_req) begin
          flush_q <= 1'b1;
        end else if (core_req) begin
          op_q  <= core_op;
          tag_q <= core_tag;
          ent_q <= core_ent;
        end
      end
      if (state == FDONE) flush_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt       = state;
    core_ready      = 1'b0;
    flush_done      = 1'b0;
    ts_read         = 1'b0;
    ts_wthru        = 1'b0;
    ts_wback        = 1'b0;
    ts_valid_clear  = 1'b0;
    ts_line_refill  = 1'b0;
    ts_writeback_ok = 1'b0;
    biu_wb_req      = 1'b0;
    biu_refill_req  = 1'b0;
    cnt_inc         = 1'b0;
    cnt_clr         = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req)     state_nxt = FLUSH;
        else if (core_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        ts_wthru = is_wthru;
        ts_wback = is_wback;
        ts_read  = !is_wthru && !is_wback;
        if (!ts_line_miss)     state_nxt = DONE;
`ifdef CACHE_CTRL_WBACK_EN
        else if (ts_replace_dirty) state_nxt = WBACK;
`endif
        else                   state_nxt = REFILL;
      end
`ifdef CACHE_CTRL_WBACK_EN
      WBACK: begin
        biu_wb_req = 1'b1;
        if (biu_wb_done) state_nxt = WB_COMMIT;
      end
      WB_COMMIT: begin
        ts_writeback_ok = 1'b1;
        state_nxt       = flush_q ? FLUSH : REFILL;
      end
`endif
      REFILL: begin
        biu_refill_req = 1'b1;
        if (biu_refill_done) state_nxt = RF_COMMIT;
      end
      RF_COMMIT: begin
        ts_line_refill = 1'b1;
        state_nxt      = LOOKUP;
      end
      DONE: begin
        core_ready = 1'b1;
        state_nxt  = IDLE;
      end
      FLUSH: begin
`ifdef CACHE_CTRL_WBACK_EN
        // A dirty line is written back first; the walk revisits the same index.
        if (ts_replace_dirty) begin
          state_nxt = WBACK;
        end else
`endif
        begin
          ts_valid_clear = 1'b1;
          if (cnt_last) state_nxt = FDONE;
          else          cnt_inc   = 1'b1;
        end
      end
      FDONE: begin
        flush_done = 1'b1;
        cnt_clr    = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign core_busy     = (state != IDLE);
  assign ts_ent        = flush_q ? cnt : ent_q;
  assign biu_ent       = flush_q ? cnt : ent_q;
  assign ts_tag        = tag_q;
  assign ts_refill_tag = tag_q;
  assign biu_tag       = tag_q;
endmodule

// File: doc/cache_ctrl_dm.md
# cache_ctrl_dm

Sequencing controller for the direct-mapped cache tag store. It accepts single core access requests and drives the tag store's lookup strobes. On a miss it orders the dirty-line writeback and the line refill through the BIU, then commits the refill back into the tag store. It also walks every entry on a flush request. It sits between the core load/store unit, the tag store and the BIU.

## Interface
- ENTRY_NUM, 16, number of cache lines
- ENTRYSEL_WID, ENTRY_NUM>1 ? $clog2(ENTRY_NUM) : 1, line index width
- TAG_WID, 14, tag width

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- core_req  in  1  single-cycle request pulse; accepted only when core_busy=0, otherwise dropped
- core_op  in  2  access type: 00 read, 01 write-through, 10 write-back, 11 treated as read
- core_tag / core_ent  in  TAG_WID / ENTRYSEL_WID  access tag and line index
- core_ready  out  1  one-cycle completion pulse
- core_busy  out  1  state != IDLE
- flush_req  in  1  flush-all pulse; accepted only when core_busy=0
- flush_done  out  1  one-cycle completion pulse
- ts_read / ts_wthru / ts_wback  out  1  tag-store lookup strobes
- ts_tag, ts_refill_tag  out  TAG_WID  lookup tag and refill tag (both driven from the latched tag)
- ts_ent  out  ENTRYSEL_WID  line index to the tag store
- ts_valid_clear, ts_line_refill, ts_writeback_ok  out  1  tag-store commands
- ts_line_miss, ts_replace_dirty  in  1  tag-store status
- biu_wb_req  out  1  writeback request; level, held until done
- biu_wb_done  in  1  writeback complete pulse
- biu_refill_req  out  1  refill request; level, held until done
- biu_refill_done  in  1  refill complete pulse
- biu_ent / biu_tag  out  ENTRYSEL_WID / TAG_WID  target line index and refill tag

## Operation
- States: IDLE, LOOKUP, WBACK, WB_COMMIT, REFILL, RF_COMMIT, DONE, FLUSH, FDONE.
- IDLE
  - flush_req has priority over core_req in the same cycle.
  - On accept, latch op, tag and ent.
- LOOKUP
  - Assert exactly one of ts_read, ts_wthru or ts_wback, per the latched op.
  - Hit (ts_line_miss=0) -> DONE.
  - Miss with ts_replace_dirty=1 -> WBACK.
  - Miss with ts_replace_dirty=0 -> REFILL.
- WBACK: biu_wb_req=1; on biu_wb_done -> WB_COMMIT.
- WB_COMMIT: ts_writeback_ok=1 for one cycle. Next state is REFILL when entered from a miss, FLUSH when entered from a flush.
- REFILL: biu_refill_req=1; on biu_refill_done -> RF_COMMIT.
- RF_COMMIT: ts_line_refill=1 for one cycle -> LOOKUP. The re-lookup hits, which also sets the dirty bit for write-back ops.
- DONE: core_ready=1 -> IDLE.
- FLUSH
  - Index counter cnt starts at 0; ts_ent=cnt.
  - If ts_replace_dirty=1 -> WBACK, with cnt held and no clear.
  - Otherwise assert ts_valid_clear. If cnt=ENTRY_NUM-1 -> FDONE, else cnt+1.
- FDONE: flush_done=1 -> IDLE; cnt returns to 0.
- ts_ent, ts_tag, ts_refill_tag, biu_ent and biu_tag are driven from latched values (cnt during a flush), never from core_* directly.
- Reset in any state:
  - Next cycle is IDLE, cnt=0 and all outputs are 0.
  - The BIU must drop any in-flight transfer when its request deasserts.

## Timing
- Reset value of every output is 0.
- Hit: core_req at cycle N, LOOKUP at N+1, core_ready at N+2, next accept at N+3.
- Clean miss: core_req at N, LOOKUP N+1, REFILL from N+2.
  - biu_refill_done at cycle M gives RF_COMMIT at M+1, LOOKUP at M+2, core_ready at M+3.
- Dirty miss inserts WBACK and WB_COMMIT: biu_wb_done at W gives WB_COMMIT at W+1 and REFILL from W+2.
- A done pulse arriving in the same cycle the state is entered is accepted.
- Done pulses outside WBACK/REFILL are ignored.
- Clean flush: flush_req at N, FLUSH cycles N+1..N+ENTRY_NUM, flush_done at N+ENTRY_NUM+1.

## Configuration
- CACHE_CTRL_WBACK_EN defined: the dirty path is compiled in (WBACK/WB_COMMIT states, flush writebacks, ts_wback strobe).
- CACHE_CTRL_WBACK_EN undefined:
  - ts_replace_dirty is ignored.
  - WBACK and WB_COMMIT are absent.
  - biu_wb_req and ts_writeback_ok are tied to 0.
  - op 10 behaves as write-through (ts_wthru).

## Structure
- Shared package cache_pkg holds the state enum, the core_op encodings (OP_READ, OP_WTHRU, OP_WBACK) and the state encoding width.
- The flush index counter with its terminal flag is the one natural sub-module: cache_flush_cnt (parameter ENTRY_NUM).

## Test plan
- Hit: preload entry 3 with tag 0x12 via a miss, then read tag 0x12 ent 3 -> core_ready exactly 2 cycles after core_req, no BIU request.
- Clean miss: read tag 0x05 ent 7, biu_refill_done 4 cycles after biu_refill_req rises -> ts_line_refill one cycle with ts_refill_tag=0x05, then core_ready 2 cycles later.
- Dirty miss (WBACK_EN):
  - Setup: write-back to tag 0x01 ent 2, then read tag 0x02 ent 2.
  - Required: biu_wb_req precedes biu_refill_req, ts_writeback_ok pulses once, core_ready follows.
- Flush, ENTRY_NUM=16, all clean: flush_done at cycle N+17, ts_valid_clear high 16 cycles with ts_ent 0..15.
- Flush with entry 9 dirty: one writeback at ent 9 occurs before its clear; flush_done still fires once.
- rst asserted while in REFILL, simultaneous flush_req+core_req in IDLE:
  - After rst: IDLE and all outputs 0 on the next cycle.
  - On the simultaneous pulses: the flush wins and the core request is dropped.
